// File: rtl/io_bridge_pkg.sv
// Shared types and constants for the CPU-to-IO bridge.
// Holds the bridge FSM state type, the field widths and the device numbers
// the IO logic decodes from dev_sel.
package io_bridge_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned WIN_W  = 2;
    localparam int unsigned DEV_W  = 3;
    localparam int unsigned REG_W  = 2;
    localparam int unsigned CNT_W  = 4;

    localparam logic [DEV_W-1:0] DEV_LED = DEV_W'(0);
    localparam logic [DEV_W-1:0] DEV_SW  = DEV_W'(1);
    localparam logic [DEV_W-1:0] DEV_BTN = DEV_W'(2);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        ACK,
        RELEASE
    } state_t;

endpackage

// File: rtl/io_addr_decode.sv
// Combinational decode of a CPU address into the IO window hit, device
// select, register select and whether that device is implemented.
// Ports:
//   addr      - CPU address
//   in_window - addr[6:5] matches IO_WIN
//   dev_sel   - addr[4:2]
//   reg_sel   - addr[1:0]
//   dev_valid - dev_sel names an implemented device (< NUM_DEV)
module io_addr_decode
    import io_bridge_pkg::*;
#(
    parameter logic [WIN_W-1:0] IO_WIN  = 2'b11,
    parameter int unsigned      NUM_DEV = 3
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              in_window,
    output logic [DEV_W-1:0]  dev_sel,
    output logic [REG_W-1:0]  reg_sel,
    output logic              dev_valid
);

    assign in_window = (addr[ADDR_W-1 -: WIN_W] == IO_WIN);
    assign dev_sel   = addr[REG_W +: DEV_W];
    assign reg_sel   = addr[REG_W-1:0];
    assign dev_valid = (32'(dev_sel) < NUM_DEV);

endmodule

// File: rtl/io_bridge.sv
// CPU-to-IO bridge: turns a held CPU read/write request inside the IO
// address window into a SETUP / ACCESS / ACK sequence toward the IO logic,
// then waits for the request to drop before accepting another
// (four-phase handshake).
// Ports:
//   clk, reset            - clock, synchronous active-low reset
//   cpu_addr, cpu_wdata   - CPU address / write data (latched in IDLE)
//   cpu_rd, cpu_wr        - request levels held until cpu_ack
//   cpu_rdata             - read data, updated only when a read completes
//   cpu_ack, cpu_err      - one-cycle completion pulse and its error flag
//   dev_sel, reg_sel      - latched device / register select
//   we, data_in           - one-cycle write strobe and latched write data
//   data_out              - read data from the IO logic
// Build option: IO_BRIDGE_ERR_EN makes accesses to unimplemented devices
// complete straight from SETUP with cpu_err=1; otherwise cpu_err stays 0.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter logic [WIN_W-1:0] IO_WIN      = 2'b11,
    parameter int unsigned      WAIT_CYCLES = 1,
    parameter int unsigned      NUM_DEV     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [DEV_W-1:0]  dev_sel,
    output logic [REG_W-1:0]  reg_sel,
    output logic              we,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
);

`ifdef IO_BRIDGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    logic              dec_in_window;
    logic [DEV_W-1:0]  dec_dev;
    logic [REG_W-1:0]  dec_reg;
    logic              dec_valid;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [DEV_W-1:0]  dev_q, dev_d;
    logic [REG_W-1:0]  reg_q, reg_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              wr_q, wr_d;
    logic              bad_q, bad_d;

    io_addr_decode #(
        .IO_WIN  (IO_WIN),
        .NUM_DEV (NUM_DEV)
    ) u_decode (
        .addr      (cpu_addr),
        .in_window (dec_in_window),
        .dev_sel   (dec_dev),
        .reg_sel   (dec_reg),
        .dev_valid (dec_valid)
    );

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            we_q    <= 1'b0;
            din_q   <= '0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            we_q    <= we_d;
            din_q   <= din_d;
            wr_q    <= wr_d;
            bad_q   <= bad_d;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dev_d   = dev_q;
        reg_d   = reg_q;
        we_d    = 1'b0;
        din_d   = din_q;
        wr_d    = wr_q;
        bad_d   = bad_q;

        case (state_q)
            IDLE: begin
                if ((cpu_rd || cpu_wr) && dec_in_window) begin
                    dev_d   = dec_dev;
                    reg_d   = dec_reg;
                    din_d   = cpu_wdata;
                    wr_d    = cpu_wr;      // write wins when both are set
                    bad_d   = ERR_EN && !dec_valid;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d = '0;
                if (bad_q) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = ACCESS;
                    we_d    = wr_q;        // strobe covers the first ACCESS cycle only
                end
            end
            ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    if (!wr_q) begin
                        rdata_d = data_out;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!cpu_rd && !cpu_wr) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ack   = ack_q;
    assign cpu_err   = err_q;
    assign dev_sel   = dev_q;
    assign reg_sel   = reg_q;
    assign we        = we_q;
    assign data_in   = din_q;

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: a directed vector table and a random
// run against a transaction-level model on a default instance, plus a
// reset-abort sequence on a WAIT_CYCLES=4 instance.
module tb_io_bridge;
    import io_bridge_pkg::*;

`ifdef IO_BRIDGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [6:0]  addr;
        logic [15:0] wdata;
        logic        rd;
        logic        wr;
        logic [15:0] dout;
        int          hold;
        bit          exp_ack;
        int          exp_lat;
        int          exp_we;
        logic [2:0]  exp_dev;
        logic [1:0]  exp_reg;
        logic [15:0] exp_din;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        reset = 1'b0;
    logic [6:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [15:0] cpu_rdata;
    logic        cpu_ack, cpu_err;
    logic [2:0]  dev_sel;
    logic [1:0]  reg_sel;
    logic        we;
    logic [15:0] data_in;
    logic [15:0] data_out = '0;

    // WAIT_CYCLES=4 instance
    logic        reset4 = 1'b0;
    logic [6:0]  addr4 = '0;
    logic [15:0] wdata4 = '0;
    logic        rd4 = 1'b0, wr4 = 1'b0;
    logic [15:0] rdata4;
    logic        ack4, err4;
    logic [2:0]  dev4;
    logic [1:0]  reg4;
    logic        we4;
    logic [15:0] din4;
    logic [15:0] dout4 = '0;

    io_bridge dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .cpu_err(cpu_err), .dev_sel(dev_sel), .reg_sel(reg_sel), .we(we),
        .data_in(data_in), .data_out(data_out)
    );

    io_bridge #(.WAIT_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset4), .cpu_addr(addr4), .cpu_wdata(wdata4),
        .cpu_rd(rd4), .cpu_wr(wr4), .cpu_rdata(rdata4), .cpu_ack(ack4),
        .cpu_err(err4), .dev_sel(dev4), .reg_sel(reg4), .we(we4),
        .data_in(din4), .data_out(dout4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one request in an IDLE cycle and compare against the vector.
    task automatic run_txn(input vec_t v);
        int          lat = -1;
        int          wes = 0;
        int          extra = 0;
        bit          seen = 0;
        logic        err_s = 1'b0;
        logic [15:0] rd_s = '0;
        logic [2:0]  dev_w = '0;
        logic [15:0] din_w = '0;
        int          limit;
        limit = v.exp_ack ? 12 : 10;
        cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_rd = v.rd; cpu_wr = v.wr;
        data_out = v.dout;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (we) begin
                wes++;
                dev_w = dev_sel;
                din_w = data_in;
            end
            if (cpu_ack) begin
                seen = 1; lat = i; err_s = cpu_err; rd_s = cpu_rdata;
                break;
            end
        end
        if (v.exp_ack) begin
            chk({v.name, ".ack_latency"}, lat, v.exp_lat);
            chk({v.name, ".err"}, {31'd0, err_s}, {31'd0, v.exp_err});
            chk({v.name, ".rdata"}, {16'd0, rd_s}, {16'd0, v.exp_rdata});
        end else begin
            chk({v.name, ".no_ack"}, {31'd0, seen}, 32'd0);
            chk({v.name, ".rdata_kept"}, {16'd0, cpu_rdata}, {16'd0, v.exp_rdata});
        end
        chk({v.name, ".we_pulses"}, wes, v.exp_we);
        if (wes > 0) begin
            chk({v.name, ".dev_at_we"}, {29'd0, dev_w}, {29'd0, v.exp_dev});
            chk({v.name, ".din_at_we"}, {16'd0, din_w}, {16'd0, v.exp_din});
        end
        chk({v.name, ".dev_sel"}, {29'd0, dev_sel}, {29'd0, v.exp_dev});
        chk({v.name, ".reg_sel"}, {30'd0, reg_sel}, {30'd0, v.exp_reg});
        chk({v.name, ".data_in"}, {16'd0, data_in}, {16'd0, v.exp_din});
        @(posedge clk); #1;
        if (seen) begin
            repeat (v.hold) begin
                @(negedge clk);
                if (cpu_ack) extra++;
                @(posedge clk); #1;
            end
            if (v.hold > 0) chk({v.name, ".held_no_reack"}, extra, 0);
        end
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        @(negedge clk);
        if (seen) chk({v.name, ".ack_one_cycle"}, {31'd0, cpu_ack}, 32'd0);
        @(posedge clk); #1;
    endtask

    vec_t        tbl [9];
    vec_t        rv;
    logic [2:0]  m_dev;
    logic [1:0]  m_reg;
    logic [15:0] m_din;
    logic [15:0] m_rdata;

    initial begin
        // name addr wdata rd wr dout hold | ack lat we dev reg din rdata err
        tbl[0] = '{"wr_led",   7'h60, 16'h00A5, 1'b0, 1'b1, 16'h0000, 0, 1'b1, 3, 1, DEV_LED, 2'd0, 16'h00A5, 16'h0000, 1'b0};
        tbl[1] = '{"rd_sw",    7'h64, 16'h1111, 1'b1, 1'b0, 16'h003C, 0, 1'b1, 3, 0, DEV_SW,  2'd0, 16'h1111, 16'h003C, 1'b0};
        tbl[2] = '{"rd_outwin",7'h10, 16'h2222, 1'b1, 1'b0, 16'hFFFF, 0, 1'b0, 0, 0, DEV_SW,  2'd0, 16'h1111, 16'h003C, 1'b0};
        tbl[3] = '{"rd_hold",  7'h6B, 16'h3333, 1'b1, 1'b0, 16'hBEEF, 5, 1'b1, 3, 0, DEV_BTN, 2'd3, 16'h3333, 16'hBEEF, 1'b0};
        tbl[4] = '{"rd_again", 7'h6B, 16'h4444, 1'b1, 1'b0, 16'h1234, 0, 1'b1, 3, 0, DEV_BTN, 2'd3, 16'h4444, 16'h1234, 1'b0};
        tbl[5] = '{"rd_wr_pri",7'h65, 16'h5A5A, 1'b1, 1'b1, 16'h9999, 0, 1'b1, 3, 1, DEV_SW,  2'd1, 16'h5A5A, 16'h1234, 1'b0};
`ifdef IO_BRIDGE_ERR_EN
        tbl[6] = '{"wr_dev3",  7'h6C, 16'h0C0C, 1'b0, 1'b1, 16'h0000, 0, 1'b1, 2, 0, 3'd3,    2'd0, 16'h0C0C, 16'h1234, 1'b1};
        tbl[7] = '{"rd_dev7",  7'h7E, 16'h0707, 1'b1, 1'b0, 16'h7777, 0, 1'b1, 2, 0, 3'd7,    2'd2, 16'h0707, 16'h1234, 1'b1};
`else
        tbl[6] = '{"wr_dev3",  7'h6C, 16'h0C0C, 1'b0, 1'b1, 16'h0000, 0, 1'b1, 3, 1, 3'd3,    2'd0, 16'h0C0C, 16'h1234, 1'b0};
        tbl[7] = '{"rd_dev7",  7'h7E, 16'h0707, 1'b1, 1'b0, 16'h7777, 0, 1'b1, 3, 0, 3'd7,    2'd2, 16'h0707, 16'h7777, 1'b0};
`endif
        tbl[8] = '{"wr_outwin",7'h2F, 16'hDEAD, 1'b0, 1'b1, 16'h0000, 0, 1'b0, 0, 0, 3'd7,    2'd2, 16'h0707, tbl[7].exp_rdata, 1'b0};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.outputs", {cpu_ack, cpu_err, we, dev_sel, reg_sel}, 32'd0);
        chk("reset.data", {cpu_rdata, data_in}, 32'd0);
        chk("reset4.outputs", {ack4, err4, we4, dev4, reg4}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; reset4 = 1'b1;

        foreach (tbl[i]) run_txn(tbl[i]);

        // random run against a transaction-level model
        m_dev = tbl[8].exp_dev; m_reg = tbl[8].exp_reg;
        m_din = tbl[8].exp_din; m_rdata = tbl[8].exp_rdata;
        for (int k = 0; k < 40; k++) begin
            bit in_win;
            bit errp;
            rv.name  = $sformatf("rand%0d", k);
            rv.addr  = 7'($urandom);
            if ($urandom_range(0, 3) != 0) rv.addr[6:5] = 2'b11;
            rv.wdata = 16'($urandom);
            rv.dout  = 16'($urandom);
            rv.wr    = 1'($urandom_range(0, 1));
            rv.rd    = rv.wr ? 1'($urandom_range(0, 1)) : 1'b1;
            rv.hold  = $urandom_range(0, 2);
            in_win   = (rv.addr[6:5] == 2'b11);
            errp     = ERR_EN && (int'(rv.addr[4:2]) >= 3);
            rv.exp_ack = in_win;
            rv.exp_lat = errp ? 2 : 3;
            rv.exp_we  = (in_win && rv.wr && !errp) ? 1 : 0;
            rv.exp_err = in_win && errp;
            if (in_win) begin
                m_dev = rv.addr[4:2];
                m_reg = rv.addr[1:0];
                m_din = rv.wdata;
                if (!rv.wr && !errp) m_rdata = rv.dout;
            end
            rv.exp_dev = m_dev; rv.exp_reg = m_reg;
            rv.exp_din = m_din; rv.exp_rdata = m_rdata;
            run_txn(rv);
        end

        // WAIT_CYCLES=4: ordinary read first so the abort has state to clear
        begin
            int lat = -1;
            int wes = 0;
            addr4 = 7'h66; rd4 = 1'b1; dout4 = 16'hABCD;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (ack4) begin lat = i; break; end
            end
            chk("w4_read.ack_latency", lat, 6);
            chk("w4_read.rdata", {16'd0, rdata4}, 32'h0000ABCD);
            @(posedge clk); #1; rd4 = 1'b0;
            @(posedge clk); #1;

            // write, reset during the second ACCESS cycle
            addr4 = 7'h61; wdata4 = 16'hC0DE; wr4 = 1'b1;
            @(posedge clk); // -> SETUP
            @(posedge clk); // -> ACCESS 1
            @(negedge clk);
            chk("w4_abort.we_first_access", {31'd0, we4}, 32'd1);
            @(posedge clk); // -> ACCESS 2
            #1 reset4 = 1'b0;
            @(posedge clk); // reset sampled
            #1 reset4 = 1'b1;
            @(negedge clk);
            chk("w4_abort.ctrl", {ack4, err4, we4, dev4, reg4}, 32'd0);
            chk("w4_abort.data", {rdata4, din4}, 32'd0);

            // request still held: treated as new from the reset edge
            lat = -1;
            for (int i = 0; i < 12; i++) begin
                if (i > 0) @(negedge clk);
                if (we4) wes++;
                if (ack4) begin lat = i; break; end
            end
            chk("w4_rehold.ack_latency", lat, 6);
            chk("w4_rehold.we_pulses", wes, 1);
            chk("w4_rehold.din", {16'd0, din4}, 32'h0000C0DE);
            chk("w4_rehold.dev", {29'd0, dev4}, 32'd0);
            chk("w4_rehold.err", {31'd0, err4}, 32'd0);
            @(posedge clk); #1; wr4 = 1'b0;
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 Parameter IO_WIN, default 2'b11, selects the IO address window: cpu_addr[6:5] == IO_WIN.
REQ-002 Parameter WAIT_CYCLES, default 1, range 1..15, is the number of ACCESS cycles before read data is sampled.
REQ-003 Parameter NUM_DEV, default 3, is the count of implemented devices (0=LED, 1=switches, 2=buttons).
REQ-004 Port clk, input, 1: single clock; every register is updated on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-low reset.
REQ-006 Port cpu_addr, input, 7: CPU address.
REQ-007 Port cpu_wdata, input, 16: CPU write data.
REQ-008 Port cpu_rd / cpu_wr, input, 1 each: request levels; the CPU holds them until cpu_ack.
REQ-009 Port cpu_rdata, output, 16: registered read data.
REQ-010 Port cpu_ack, output, 1: one-cycle completion pulse.
REQ-011 Port cpu_err, output, 1: error flag, valid with cpu_ack.
REQ-012 Port dev_sel, output, 3: device select toward the IO logic.
REQ-013 Port reg_sel, output, 2: register select toward the IO logic.
REQ-014 Port we, output, 1: write enable toward the IO logic.
REQ-015 Port data_in, output, 16: write data toward the IO logic.
REQ-016 Port data_out, input, 16: read data from the IO logic.

Function
REQ-017 The FSM SHALL have five states: IDLE, SETUP, ACCESS, ACK and RELEASE.
REQ-018 IDLE: when (cpu_rd|cpu_wr) is asserted and the address is in the window, the block SHALL latch the address, wdata and operation, then go to SETUP; a write SHALL take priority if cpu_rd and cpu_wr are both asserted.
REQ-019 An out-of-window request SHALL be ignored: stay in IDLE, no ack, device outputs unchanged.
REQ-020 dev_sel SHALL equal latched addr[4:2], reg_sel SHALL equal latched addr[1:0], and data_in SHALL equal latched wdata; all three SHALL be held from SETUP until the next latch.
REQ-021 SETUP SHALL last 1 cycle with we=0, then go to ACCESS.
REQ-022 ACCESS SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit counter.
REQ-023 we SHALL be 1 only in the first ACCESS cycle of a write, giving exactly one pulse per write.
REQ-024 On the last ACCESS cycle of a read, data_out SHALL be registered into cpu_rdata.
REQ-025 cpu_rdata SHALL hold its value until the next read completes; writes SHALL leave it unchanged.
REQ-026 ACK: cpu_ack=1 for exactly one cycle, then go to RELEASE.
REQ-027 Latency: with the request first seen in IDLE at cycle N, cpu_ack SHALL be asserted at cycle N+2+WAIT_CYCLES (N+3 at the default).
REQ-028 RELEASE SHALL stay until cpu_rd and cpu_wr are both 0, then go to IDLE; a request held high SHALL never produce a second ack (four-phase handshake).
REQ-029 Address or data changes while the FSM is not in IDLE SHALL be ignored.

Reset
REQ-030 While reset=0 at a clock edge, the block SHALL enter IDLE and clear cpu_rdata, cpu_ack, cpu_err, dev_sel, reg_sel, we, data_in and the counter to 0, from any state.
REQ-031 Reset during ACCESS SHALL abort the transfer with no ack and we=0 from the next edge.
REQ-032 A request still held after reset release SHALL be treated as new in IDLE.

Configuration
REQ-033 With IO_BRIDGE_ERR_EN defined, a latched dev_sel >= NUM_DEV SHALL go SETUP -> ACK, skipping ACCESS.
REQ-034 In that case there SHALL be no we pulse, cpu_rdata SHALL be unchanged, and cpu_err=1 with cpu_ack.
REQ-035 With IO_BRIDGE_ERR_EN undefined, cpu_err SHALL be tied to 0 and every in-window access SHALL follow the normal path.

Structure
REQ-036 Package io_bridge_pkg SHALL hold the state typedef, the DEV_LED=0, DEV_SW=1 and DEV_BTN=2 constants, and the window width.
REQ-037 One combinational sub-module, io_addr_decode, SHALL compute in_window, dev_sel, reg_sel and dev_valid; the FSM, counter and registers SHALL live in io_bridge; the target size is 150-250 lines.

Verification
REQ-038 Write 16'h00A5 to addr 7'h60 -> one we pulse with dev_sel=0 and data_in=16'h00A5; cpu_ack at N+3.
REQ-039 Read addr 7'h64 with a stub data_out of 16'h003C -> cpu_rdata=16'h003C together with cpu_ack at N+3, err=0.
REQ-040 Read addr 7'h10 held for 10 cycles -> no ack, we=0, dev_sel/reg_sel unchanged.
REQ-041 Hold cpu_rd for 5 cycles after ack -> no second ack; drop then reassert -> new ack.
REQ-042 WAIT_CYCLES=4, reset=0 in the 2nd ACCESS cycle -> no ack, all outputs 0; with the request held after release -> ack 6 cycles after the first post-reset edge.
REQ-043 Write to addr 7'h6C (dev 3): with IO_BRIDGE_ERR_EN -> ack with err=1 and no we; without it -> we pulse, ack, err=0.
